// File: rtl/bit_4_ripple_carry_adder_pkg.sv
// Shared constants for the registered 4-bit adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bit_4_ripple_carry_adder_pkg;

    // Operand width. The carry equations in cla_4_core are written out flat
    // for exactly this width, so changing it means rewriting the core.
    localparam int ADD_W = 4;

endpackage : bit_4_ripple_carry_adder_pkg

// File: rtl/bit_4_ripple_carry_adder_cla_4_core.sv
// Combinational 4-bit carry-lookahead adder core with group P/G outputs.
// Latency: 0 cycles (pure logic).
// Backpressure: none; result follows the inputs continuously.
module cla_4_core
    import bit_4_ripple_carry_adder_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             c_0,
    output logic [ADD_W-1:0] sum,
    output logic             cout,
    output logic             P,
    output logic             G
);

    // Per-bit generate and propagate terms.
    logic [ADD_W-1:0] w_g;
    logic [ADD_W-1:0] w_p;

    // Carry into each bit position, plus carry-out of bit 3.
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;
    logic             w_c4;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum of products of g/p terms and c_0; no carry is
    // built from another carry, so depth stays two levels for all positions.
    assign w_c1 = w_g[0]
                | (w_p[0] & c_0);

    assign w_c2 = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & c_0);

    assign w_c3 = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_0);

    assign w_c4 = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_0);

    // Sum bit i is the propagate term XOR the carry into that bit.
    assign sum[0] = w_p[0] ^ c_0;
    assign sum[1] = w_p[1] ^ w_c1;
    assign sum[2] = w_p[2] ^ w_c2;
    assign sum[3] = w_p[3] ^ w_c3;

    assign cout = w_c4;

    // Group terms for cascading into a higher-level lookahead unit:
    // carry-out of the group equals G | (P & c_0).
    assign P = w_p[3] & w_p[2] & w_p[1] & w_p[0];

    assign G = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_4_core

// File: rtl/bit_4_ripple_carry_adder.sv
// Registered 4-bit adder: {c_4, s} = a + b + c_0 via a lookahead core.
// Latency: 1 cycle; one addition accepted every cycle.
// Backpressure: none; no handshake, inputs sampled on every rising edge.
module bit_4_ripple_carry_adder
    import bit_4_ripple_carry_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             c_0,
    output logic [ADD_W-1:0] s,
    output logic             c_4
);

    logic [ADD_W-1:0] w_sum;
    logic             w_cout;
    logic             w_grp_p;
    logic             w_grp_g;

    // Group P/G are exported by the core for future cascading; this single
    // 4-bit instance has no consumer for them yet.
    logic             w_unused_grp;

    logic [ADD_W-1:0] r_s;
    logic             r_c4;

    cla_4_core u_cla_4_core (
        .a    (a),
        .b    (b),
        .c_0  (c_0),
        .sum  (w_sum),
        .cout (w_cout),
        .P    (w_grp_p),
        .G    (w_grp_g)
    );

    assign w_unused_grp = w_grp_p ^ w_grp_g;

    // Output register: cleared asynchronously by rst, otherwise loads the
    // core result on every rising clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= '0;
            r_c4 <= 1'b0;
        end else begin
            r_s  <= w_sum;
            r_c4 <= w_cout;
        end
    end

    assign s   = r_s;
    assign c_4 = r_c4;

endmodule : bit_4_ripple_carry_adder

// File: tb/tb_bit_4_ripple_carry_adder.sv
module tb_bit_4_ripple_carry_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_0;
    logic [3:0] s;
    logic       c_4;

    int total;
    int bad;

    bit_4_ripple_carry_adder dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c_0 (c_0),
        .s   (s),
        .c_4 (c_4)
    );

    // Rising edges at 5, 15, 25 ns...; inputs driven and outputs sampled on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer addition.
    function automatic int ref_add(input int x, input int y, input int c);
        return x + y + c;
    endfunction

    task automatic check_out(input string name, input int exp);
        int got;
        got = int'({c_4, s});
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {c_4,s}=%0d (s=%0d c_4=%0d) expected %0d", name, got, s, c_4, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic apply_one(input int x, input int y, input int c);
        @(negedge clk);
        a   = 4'(x);
        b   = 4'(y);
        c_0 = 1'(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        // Load a non-zero result first so the asynchronous clear is visible.
        rst = 1'b0;
        apply_one(5, 5, 0);
        check_out("pre_reset_load", 10);
        #2;
        rst = 1'b1;
        #1;
        check_out("reset_async_clear", 0);
        a = 4'd15; b = 4'd15; c_0 = 1'b1;
        #1;
        check_out("reset_inputs_ignored", 0);
        @(posedge clk);
        @(negedge clk);
        check_out("reset_hold_over_edge", 0);
        a = 4'd3; b = 4'd4; c_0 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("post_reset_3_plus_4", 7);
    endtask

    task automatic test_directed;
        apply_one(15, 0, 1);  check_out("dir_15_0_1", 16);
        apply_one(15, 1, 0);  check_out("dir_15_1_0", 16);
        apply_one(7, 8, 0);   check_out("dir_7_8_0", 15);
        apply_one(9, 6, 1);   check_out("dir_9_6_1", 16);
        apply_one(15, 15, 1); check_out("dir_15_15_1", 31);
        apply_one(0, 0, 0);   check_out("dir_0_0_0", 0);
    endtask

    // All 512 combinations, one per cycle; each falling edge checks the
    // result of the vector driven one cycle earlier, then drives the next.
    task automatic test_sweep;
        int exp_prev;
        bit have_prev;
        have_prev = 1'b0;
        exp_prev  = 0;
        for (int v = 0; v < 512; v++) begin
            @(negedge clk);
            if (have_prev) check_out("sweep", exp_prev);
            a   = 4'(v >> 5);
            b   = 4'(v >> 1);
            c_0 = 1'(v);
            exp_prev  = ref_add((v >> 5) & 15, (v >> 1) & 15, v & 1);
            have_prev = 1'b1;
        end
        @(negedge clk);
        check_out("sweep_last", exp_prev);
    endtask

    task automatic test_back_to_back;
        int exp_prev;
        int x, y, c;
        @(negedge clk);
        x = int'($urandom_range(15, 0));
        y = int'($urandom_range(15, 0));
        c = int'($urandom_range(1, 0));
        a = 4'(x); b = 4'(y); c_0 = 1'(c);
        exp_prev = ref_add(x, y, c);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check_out("random_b2b", exp_prev);
            x = int'($urandom_range(15, 0));
            y = int'($urandom_range(15, 0));
            c = int'($urandom_range(1, 0));
            a = 4'(x); b = 4'(y); c_0 = 1'(c);
            exp_prev = ref_add(x, y, c);
        end
        @(negedge clk);
        check_out("random_b2b_last", exp_prev);
    endtask

    task automatic test_mid_cycle;
        apply_one(5, 0, 0);
        check_out("midcyc_initial", 5);
        #2;
        a = 4'd6;
        #1;
        check_out("midcyc_held", 5);
        @(posedge clk);
        @(negedge clk);
        check_out("midcyc_next_edge", 6);
    endtask

    task automatic test_mid_reset;
        apply_one(9, 9, 1);
        check_out("midrst_loaded", 19);
        #2;
        rst = 1'b1;
        #1;
        check_out("midrst_async_clear", 0);
        @(posedge clk);
        @(negedge clk);
        check_out("midrst_hold", 0);
        a = 4'd12; b = 4'd10; c_0 = 1'b1;
        rst = 1'b0;
        #1;
        check_out("midrst_no_edge_yet", 0);
        @(posedge clk);
        @(negedge clk);
        check_out("midrst_first_edge", 23);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        c_0   = 1'b0;
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_mid_cycle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_4_ripple_carry_adder

// File: doc/bit_4_ripple_carry_adder.md
# bit_4_ripple_carry_adder

Registered 4-bit binary adder with carry-in and carry-out, for small datapath arithmetic. Computes a + b + c_0 through a carry-lookahead core and registers the 5-bit result on the clock. The historical "ripple_carry" name is kept for compatibility. No carry ripples through the sum stages: every carry comes straight from generate/propagate terms.

## Interface
- Parameters: none. Width is fixed at 4 bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all output registers.
- a    input  4  addend A, unsigned.
- b    input  4  addend B, unsigned.
- c_0  input  1  carry-in to bit 0.
- s    output 4  registered sum bits [3:0].
- c_4  output 1  registered carry-out of bit 3, i.e. sum bit 4.

## Operation
- Per bit i, for i = 0..3:
  - generate g_i = a_i & b_i
  - propagate p_i = a_i ^ b_i
- Carries, in flat two-level lookahead form, none derived from another carry:
  - c_1 = g_0 | p_0·c_0
  - c_2 = g_1 | p_1·g_0 | p_1·p_0·c_0
  - c_3 = g_2 | p_2·g_1 | p_2·p_1·g_0 | p_2·p_1·p_0·c_0
  - c_4 = g_3 | p_3·g_2 | p_3·p_2·g_1 | p_3·p_2·p_1·g_0 | p_3·p_2·p_1·p_0·c_0
- Sum: s_i = p_i ^ c_i.
- Arithmetic: {c_4, s} = a + b + c_0, exact over all 512 input combinations. The result range is 0..31 and never overflows 5 bits.
- Unsigned only. No signed-overflow flag.
- X/Z on inputs is not handled specially.

## Timing
- a, b and c_0 are sampled at each rising clk edge while rst is low.
- Latency is 1 cycle: the result of the inputs sampled at edge N appears on s/c_4 just after edge N.
- Throughput is one addition per cycle. There is no handshake and no valid signal.
- Input changes between edges have no effect on outputs until the next edge.
- rst asserted, including mid-stream: s = 4'b0000 and c_4 = 0 immediately, without waiting for a clock. They hold while rst is high.
- On rst deassertion, the first rising edge with rst low loads the current inputs' result.
- Reset value of every output is 0.

## Structure
- Shared package holds only the constant ADD_W = 4, used for port widths. No typedefs are needed.
- One sub-module, cla_4_core:
  - purely combinational; inputs a[3:0], b[3:0], c_0; outputs sum[3:0], cout.
  - also exports group propagate P = p_3·p_2·p_1·p_0 and group generate G (the c_4 expression without its c_0 term), for future cascading.
- Top level instantiates cla_4_core and a 5-bit output register with asynchronous reset.

## Test plan
- Apply rst=1, then any inputs with no clk edge -> s=0 and c_4=0 immediately. After release and one edge with a=3, b=4, c_0=0 -> s=7, c_4=0.
- a=15, b=0, c_0=1 -> after one edge s=0, c_4=1 (carry through all four propagate stages). Then a=15, b=1, c_0=0 -> s=0, c_4=1.
- a=7, b=8, c_0=0 -> s=15, c_4=0. Then a=9, b=6, c_0=1 -> s=0, c_4=1. Then a=15, b=15, c_0=1 -> s=15, c_4=1.
- Exhaustive sweep of all 512 {a, b, c_0} combinations, one per cycle -> {c_4, s} equals the previous cycle's a+b+c_0 every cycle. The toggle stimulus on half-periods 5/10/…/45 ns is acceptable as long as sampling is clocked.
- Change inputs between edges (e.g. a 5→6 mid-cycle) -> outputs unchanged until the next rising edge.
- Assert rst mid-stream with a non-zero result held -> s and c_4 clear asynchronously. Deassert -> the first edge loads the current sum.
